// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver:
// active-low hex glyph table, all-off levels and the digit index type.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}; a cleared bit lights the segment.
  localparam logic [6:0] HEX_CODE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = 2'd3;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the scan driver: counter value, enable and decimal
// point requests in, active-low segment/anode/dp lines and frame pulse out.
interface seg7_scan_driver_if;

  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  modport master (
    output en, value, dp_in,
    input  seg, an, dp, frame_start
  );

  modport slave (
    input  en, value, dp_in,
    output seg, an, dp, frame_start
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_CODE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame value capture and
// anode-off guard cycles. Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks
// leading zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clkin,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             load_q, load_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             slotEnd;
  logic             frameEnd;
  logic [3:0]       nibble;
  logic [6:0]       hexSeg;
  logic             digitSuppress;

  assign slotEnd  = (cnt_q == CNT_LAST);
  assign frameEnd = slotEnd && (idx_q == LAST_DIGIT);
  assign nibble   = shadow_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble_i (nibble),
    .seg_o    (hexSeg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every more significant nibble are zero.
  always_comb begin
    case (idx_q)
      2'd3:    digitSuppress = (shadow_q[15:12] == 4'h0);
      2'd2:    digitSuppress = (shadow_q[15:8]  == 8'h00);
      2'd1:    digitSuppress = (shadow_q[15:4]  == 12'h000);
      default: digitSuppress = 1'b0;
    endcase
  end
`else
  assign digitSuppress = 1'b0;
`endif

  // load_q marks the shadow capture so frame_start lands on the clock after it.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    load_d        = 1'b0;
    frame_start_d = 1'b0;
    an_d          = AN_OFF;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    if (bus.en) begin
      frame_start_d = load_q;
      if (slotEnd) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (frameEnd) begin
        shadow_d = bus.value;
        load_d   = 1'b1;
      end
      if ((cnt_q >= CNT_LIT) && !digitSuppress) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hexSeg;
        dp_d  = ~bus.dp_in[idx_q];
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= 16'h0000;
      load_q        <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      load_q        <= load_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at REFRESH_DIV=8, BLANK_CYCLES=2;
// honours SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [12:0] OFF_V = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  logic [12:0] sbQ [$];
  int          mAct;
  logic [15:0] mShadow;
  logic        mPrevLoad;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clkin (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexRef(input logic [3:0] n);
    case (n)
      4'h0: hexRef = 7'h40; 4'h1: hexRef = 7'h79; 4'h2: hexRef = 7'h24; 4'h3: hexRef = 7'h30;
      4'h4: hexRef = 7'h19; 4'h5: hexRef = 7'h12; 4'h6: hexRef = 7'h02; 4'h7: hexRef = 7'h78;
      4'h8: hexRef = 7'h00; 4'h9: hexRef = 7'h10; 4'hA: hexRef = 7'h08; 4'hB: hexRef = 7'h03;
      4'hC: hexRef = 7'h46; 4'hD: hexRef = 7'h21; 4'hE: hexRef = 7'h06; default: hexRef = 7'h0E;
    endcase
  endfunction

  task automatic modelReset();
    mAct      = 0;
    mShadow   = 16'h0000;
    mPrevLoad = 1'b0;
    sbQ.delete();
  endtask

  // Expected outputs for the coming edge from the number of enabled edges seen.
  task automatic modelPush();
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expDp, expFs, sup;
    int         pos, slot, c;
    expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expFs = 1'b0;
    if (bus.en) begin
      pos   = mAct % FRAME;
      slot  = pos / RD;
      c     = pos % RD;
      expFs = mPrevLoad;
      sup   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (mShadow >> (4 * slot)) == 16'h0) sup = 1'b1;
`endif
      if (c >= BC && !sup) begin
        expAn  = ~(4'b0001 << slot);
        expSeg = hexRef(mShadow[slot*4 +: 4]);
        expDp  = ~bus.dp_in[slot];
      end
      mPrevLoad = (pos == FRAME - 1);
      if (pos == FRAME - 1) mShadow = bus.value;
      mAct++;
    end else begin
      mPrevLoad = 1'b0;
    end
    sbQ.push_back({expAn, expSeg, expDp, expFs});
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b1;
    bus.en = 1'b1; bus.value = 16'h9035; bus.dp_in = 4'b0100;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      compared++;
      if (obs !== OFF_V) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, OFF_V);
      end
    end
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_first_frame();
    logic [12:0] obs, expV;
    for (int i = 0; i < FRAME + 1; i++) begin
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL first_frame cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
  endtask

  task automatic test_value_change();
    logic [12:0] obs, expV;
    for (int i = 0; i < 64; i++) begin
      if (i == 16) bus.value = 16'h0001;
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL value_change cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [12:0] obs, expV;
    for (int i = 0; i < 63; i++) begin
      bus.en = !(i >= 3 && i < 23);
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL enable_freeze cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
    bus.en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [12:0] obs, expV;
    for (int i = 0; i < 5; i++) begin
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL pre_reset cyc=%0d got=%h want=%h", i, obs, expV);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
    compared++;
    if (obs !== OFF_V) begin
      mismatched++;
      $display("[TB] FAIL async_reset got=%h want=%h", obs, OFF_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    bus.value = 16'hBEEF;
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL restart cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] obs, expV;
    for (int i = 0; i < 240; i++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.value = 16'($urandom_range(0, 65535));
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL random cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
    bus.en = 1'b1;
  endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [12:0] obs, expV;
    logic        sawTop;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    bus.en = 1'b1; bus.dp_in = 4'b0000; bus.value = 16'h0035;
    sawTop = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 2 * FRAME - 4) bus.value = 16'h0000;
      modelPush();
      @(posedge clk); #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
      if (bus.an == 4'b0111) sawTop = 1'b1;
      expV = sbQ.pop_front();
      compared++;
      if (obs !== expV) begin
        mismatched++;
        $display("[TB] FAIL leading_zero cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                 i, obs[12:9], obs[8:2], obs[1], obs[0], expV[12:9], expV[8:2], expV[1], expV[0]);
      end
    end
    compared++;
    if (sawTop !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lz_top_digit got=%b want=0", sawTop);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_value_change();
    test_enable_freeze();
    test_async_reset();
    test_random();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
